// File: rtl/zbt_display_reader.sv
// Read side of the NTSC frame store: forecasts the XVGA beam, issues ZBT reads
// ahead of it, unpacks 36-bit words into 18-bit pixels and realigns the syncs.
module zbt_display_reader #(
   parameter int unsigned H_TOTAL  = 1344,
   parameter int unsigned V_TOTAL  = 806,
   parameter int unsigned ZBT_LAT  = 2,
   parameter int unsigned FORECAST = 4,
   parameter int unsigned X_LO     = 150,
   parameter int unsigned X_HI     = 1023,
   parameter int unsigned Y_LO     = 100,
   parameter int unsigned Y_HI     = 767
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        blank,
   input  logic [35:0] vram_read_data,
   output logic [18:0] vram_addr,
   output logic        vram_re,
   output logic [17:0] pixel,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        blank_out
);

   localparam int unsigned HW  = 11;
   localparam int unsigned VW  = 10;
   localparam int unsigned FW  = 12;
   localparam int unsigned PW  = 18;
   localparam int unsigned DW  = 36;
   localparam int unsigned AW  = 19;

   typedef enum logic {
      WAIT_VS = 1'b0,
      RUN     = 1'b1
   } state_t;

   state_t               state_q;
   state_t               state_d;

   logic [DW-1:0]        word_q;
   logic [ZBT_LAT-1:0]   re_pipe_q;

   logic [FW-1:0]        hf_sum_c;
   logic                 hwrap_c;
   logic [FW-1:0]        hf_c;
   logic [VW:0]          vinc_c;
   logic [VW-1:0]        vf_c;
   logic                 issue_c;
   logic [AW-1:0]        addr_c;
   logic                 visible_c;
   logic [PW-1:0]        pixel_c;

   // Beam forecast: FORECAST pixels ahead, wrapping line and frame.
   always_comb begin
      hf_sum_c = FW'(hcount) + FW'(FORECAST);
      hwrap_c  = (hf_sum_c >= FW'(H_TOTAL));
      hf_c     = hf_sum_c;
      vinc_c   = (VW+1)'(vcount) + (VW+1)'(1);
      vf_c     = vcount;
      if (hwrap_c) begin
         hf_c = hf_sum_c - FW'(H_TOTAL);
         vf_c = (vinc_c == (VW+1)'(V_TOTAL)) ? '0 : VW'(vinc_c);
      end
   end

   // Next state plus read-issue and pixel-select decisions.
   always_comb begin
      state_d   = state_q;
      issue_c   = 1'b0;
      addr_c    = {vf_c, hf_c[9:1]};
      visible_c = 1'b0;
      pixel_c   = '0;

      case (state_q)
         WAIT_VS: begin
            // vsync_out holds the previous-cycle vsync
            if (vsync_out && !vsync) begin
               state_d = RUN;
            end
         end
         RUN: begin
            issue_c = !hf_c[0] && (hf_c <= FW'(X_HI)) && (vf_c <= VW'(Y_HI));
         end
         default: begin
            state_d = WAIT_VS;
         end
      endcase

      visible_c = (state_q == RUN) && !blank &&
                  (hcount >= HW'(X_LO)) && (hcount <= HW'(X_HI)) &&
                  (vcount >= VW'(Y_LO)) && (vcount <= VW'(Y_HI));
      if (visible_c) begin
         pixel_c = hcount[0] ? word_q[PW-1:0] : word_q[DW-1:PW];
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= WAIT_VS;
      end else begin
         state_q <= state_d;
      end
   end

   // Read address/strobe; address holds between issues.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vram_addr <= '0;
         vram_re   <= 1'b0;
      end else begin
         vram_re <= issue_c;
         if (issue_c) begin
            vram_addr <= addr_c;
         end
      end
   end

   // Return path: strobe latency pipe and word capture when data is valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         re_pipe_q <= '0;
         word_q    <= '0;
      end else begin
         re_pipe_q <= {re_pipe_q[ZBT_LAT-2:0], vram_re};
         if (re_pipe_q[ZBT_LAT-1]) begin
            word_q <= vram_read_data;
         end
      end
   end

   // Pixel and sync outputs, one cycle behind the beam inputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pixel     <= '0;
         hsync_out <= 1'b1;
         vsync_out <= 1'b1;
         blank_out <= 1'b1;
      end else begin
         pixel     <= pixel_c;
         hsync_out <= hsync;
         vsync_out <= vsync;
         blank_out <= blank;
      end
   end

endmodule

// File: tb/tb_zbt_display_reader.sv
// Directed bench for zbt_display_reader with a beam-level reference model.
module tb_zbt_display_reader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [10:0] hcount = '0;
   logic [9:0]  vcount = '0;
   logic        hsync = 1'b1;
   logic        vsync = 1'b1;
   logic        blank = 1'b1;
   logic [35:0] vram_read_data;
   logic [18:0] vram_addr;
   logic        vram_re;
   logic [17:0] pixel;
   logic        hsync_out;
   logic        vsync_out;
   logic        blank_out;

   int n_vec = 0;
   int n_err = 0;
   int re_cnt = 0;
   int force_blank_h = -1;
   bit vs_hold = 1'b0;
   bit done = 1'b0;

   zbt_display_reader dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .hcount         (hcount),
      .vcount         (vcount),
      .hsync          (hsync),
      .vsync          (vsync),
      .blank          (blank),
      .vram_read_data (vram_read_data),
      .vram_addr      (vram_addr),
      .vram_re        (vram_re),
      .pixel          (pixel),
      .hsync_out      (hsync_out),
      .vsync_out      (vsync_out),
      .blank_out      (blank_out)
   );

   always #5 clk = ~clk;

   // Frame-store contents as a function of word address; halves always differ.
   function automatic logic [35:0] zbt_word(input logic [18:0] a);
      if (a == 19'({9'd100, 1'b0, 9'd76}))
         return {18'h2AAAA, 18'h15555};
      return {~a[17:0], a[17:0]};
   endfunction

   // ZBT memory: data valid exactly ZBT_LAT cycles after the registered address.
   logic [18:0] addr_d1 = '0, addr_d2 = '0;
   logic        re_d1 = 1'b0, re_d2 = 1'b0;
   always @(posedge clk) begin
      addr_d1 <= vram_addr;
      addr_d2 <= addr_d1;
      re_d1   <= vram_re;
      re_d2   <= re_d1;
   end
   assign vram_read_data = re_d2 ? zbt_word(addr_d2) : 36'h0DEADBEEF;

   // Beam look-ahead by 4 pixels on a 1344 x 806 raster.
   function automatic int fc_h(input int h);
      return (h + 4 >= 1344) ? h + 4 - 1344 : h + 4;
   endfunction
   function automatic int fc_v(input int h, input int v);
      if (h + 4 < 1344) return v;
      return (v + 1 == 806) ? 0 : v + 1;
   endfunction

   function automatic logic [17:0] model_pix(input bit run, input int h, input int v,
                                             input logic bl, input logic [35:0] w);
      if (!run || bl || h < 150 || h > 1023 || v < 100 || v > 767) return 18'h0;
      return (h % 2 == 1) ? w[17:0] : w[35:18];
   endfunction

   typedef struct {
      int          due;
      logic [18:0] a;
   } req_t;

   req_t        q[$];
   bit          running;
   logic        vs_prev;
   logic [35:0] mword;
   int          cyc;
   logic        exp_re, exp_hs, exp_vs, exp_bl;
   logic [18:0] exp_addr;
   logic [17:0] exp_pix;

   // Reference model: each requested word is loaded 3 edges after its request.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         running  <= 1'b0;
         vs_prev  <= 1'b1;
         mword    <= '0;
         cyc      <= 0;
         q.delete();
         exp_re   <= 1'b0;
         exp_addr <= '0;
         exp_pix  <= '0;
         exp_hs   <= 1'b1;
         exp_vs   <= 1'b1;
         exp_bl   <= 1'b1;
      end else begin
         cyc    <= cyc + 1;
         exp_hs <= hsync;
         exp_vs <= vsync;
         exp_bl <= blank;
         if (running && fc_h(int'(hcount)) % 2 == 0 && fc_h(int'(hcount)) < 1024 &&
             fc_v(int'(hcount), int'(vcount)) < 768) begin
            exp_re   <= 1'b1;
            exp_addr <= 19'(fc_v(int'(hcount), int'(vcount)) * 512 + fc_h(int'(hcount)) / 2);
            q.push_back('{cyc + 3,
                          19'(fc_v(int'(hcount), int'(vcount)) * 512 + fc_h(int'(hcount)) / 2)});
         end else begin
            exp_re <= 1'b0;
         end
         if (q.size() > 0 && q[0].due == cyc) begin
            mword <= zbt_word(q[0].a);
            void'(q.pop_front());
         end
         exp_pix <= model_pix(running, int'(hcount), int'(vcount), blank, mword);
         if (!running && vs_prev && !vsync) running <= 1'b1;
         vs_prev <= vsync;
      end
   end

   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (!done) begin
         chk("vram_re",   36'(vram_re),   36'(exp_re));
         chk("vram_addr", 36'(vram_addr), 36'(exp_addr));
         chk("pixel",     36'(pixel),     36'(exp_pix));
         chk("hsync_out", 36'(hsync_out), 36'(exp_hs));
         chk("vsync_out", 36'(vsync_out), 36'(exp_vs));
         chk("blank_out", 36'(blank_out), 36'(exp_bl));
      end
   end

   // Drive n consecutive raster positions starting at (h0, v0).
   task automatic beam(input int h0, input int v0, input int n);
      int h = h0;
      int v = v0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         re_cnt += int'(vram_re);
         hcount = 11'(h);
         vcount = 10'(v);
         blank  = (h >= 1024) || (v >= 768) || (h == force_blank_h);
         hsync  = !(h >= 1048 && h < 1184);
         vsync  = vs_hold ? 1'b1 : !(v >= 771 && v < 777);
         h++;
         if (h == 1344) begin
            h = 0;
            v = (v + 1 == 806) ? 0 : v + 1;
         end
      end
   endtask

   // One cycle with vsync low to arm the reader.
   task automatic tick_vs(input int h, input int v);
      @(negedge clk);
      re_cnt += int'(vram_re);
      hcount = 11'(h);
      vcount = 10'(v);
      blank  = 1'b1;
      hsync  = 1'b1;
      vsync  = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_addr"},  36'(vram_addr), 36'h0);
      chk({tag, "_re"},    36'(vram_re),   36'h0);
      chk({tag, "_pixel"}, 36'(pixel),     36'h0);
      chk({tag, "_hs"},    36'(hsync_out), 36'h1);
      chk({tag, "_vs"},    36'(vsync_out), 36'h1);
      chk({tag, "_bl"},    36'(blank_out), 36'h1);
   endtask

   initial begin
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #2 chk_reset_vals("por");
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Idle: vsync held high, nothing may be read.
      vs_hold = 1'b1;
      re_cnt  = 0;
      beam(0, 0, 2000);
      chk("idle_re_count", 36'(re_cnt), 36'd0);
      vs_hold = 1'b0;

      // Arm, then first read at hcount 148 for forecast column 152.
      tick_vs(139, 200);
      beam(140, 200, 9);
      beam(149, 200, 1);
      chk("first_addr", 36'(vram_addr), 36'({9'd100, 1'b0, 9'd76}));
      chk("first_re",   36'(vram_re),   36'h1);
      beam(150, 200, 3);
      beam(153, 200, 1);
      chk("pix_even_152", 36'(pixel), 36'h2AAAA);
      beam(154, 200, 1);
      chk("pix_odd_153",  36'(pixel), 36'h15555);

      // Line and frame wrap of the forecast.
      beam(1330, 805, 13);
      beam(1343, 805, 1);
      chk("wrap_addr", 36'(vram_addr), 36'({9'd0, 1'b0, 9'd1}));
      chk("wrap_re",   36'(vram_re),   36'h1);

      // Left margin and forced blank.
      beam(90, 300, 11);
      beam(101, 300, 1);
      chk("left_margin_pix", 36'(pixel), 36'h0);
      force_blank_h = 500;
      beam(102, 300, 399);
      beam(501, 300, 1);
      chk("blank_pix", 36'(pixel), 36'h0);
      force_blank_h = -1;

      // Right edge sweep: hf 1020..1030 issues only 1020 and 1022.
      beam(1010, 400, 7);
      re_cnt = 0;
      beam(1017, 400, 11);
      chk("edge_re_count", 36'(re_cnt), 36'd2);
      chk("edge_last_addr", 36'(vram_addr), 36'({9'd200, 1'b0, 9'd511}));

      // Mid-line reset pulse.
      beam(600, 450, 5);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 chk_reset_vals("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      re_cnt = 0;
      beam(605, 450, 300);
      chk("post_reset_re_count", 36'(re_cnt), 36'd0);

      // Re-arm and scan a full line: 510 reads on line 460 plus 2 on line 461.
      tick_vs(1343, 459);
      re_cnt = 0;
      beam(0, 460, 1344);
      beam(0, 461, 1);
      chk("full_line_re_count", 36'(re_cnt), 36'd512);

      beam(1, 461, 20);
      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
